mem_wb_stage: RTL and testbench

Memory-access stage that consumes the EX/MEM pipeline register outputs and produces the MEM/WB pipeline register feeding register-file write-back. It drives a req/ack data-memory port and supports variable-latency memory, stalling upstream stages while an access is outstanding. It performs byte-lane steering for stores and sign/zero extension for loads, and flags misaligned accesses.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/mem_wb_stage.sv | 155 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS memory stage.
//   - opcode constants for the loads and stores the stage understands
//   - MEM FSM state encoding
//   - access-size type and the opcode -> size decode helper
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic { MS_IDLE, MS_ACCESS } mem_state_e;

    typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } acc_size_e;

    // Unknown opcodes that still carry memr/memw fall back to a word access.
    function automatic acc_size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
            default:              op_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic for the memory stage.
// Little-endian lane numbering: byte n of the word lives in bits [8n+7:8n].
// Ports:
//   op         in   6  opcode (selects size and sign)
//   addr_lo    in   2  low address bits
//   store_data in  32  raw store data (rd2)
//   load_word  in  32  word returned by memory
//   be         out  4  byte enables for the store/load
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  selected and extended load value
//   misalign   out  1  address not aligned to the access size
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    acc_size_e   size;
    logic        sext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        size     = op_size(op);
        sext     = (op == OP_LB) || (op == OP_LH);
        byte_sel = load_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
        misalign  = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sext & half_sel[15]}}, half_sel};
                misalign  = addr_lo[0];
            end
            default: begin
                misalign  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM pipeline stage plus the MEM/WB pipeline register.
// Issues load/store requests on a req/ack data-memory port, stalls the
// upstream pipe while an access is outstanding, and writes back either the
// ALU result or the extended load value.
// Optional: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYC
// request cycles without ack (reported through wb_misalign).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   aluout, rd2, rd, op            EX/MEM payload
//   memr, memw, regw, mem2r, flush EX/MEM control
//   dmem_req/we/addr/be/wdata      registered memory request
//   dmem_ack, dmem_rdata           memory response
//   mem_stall                      hold EX/MEM and upstream
//   wb_data, wb_rd, wb_regw, wb_misalign   MEM/WB register
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   aluout,
    input  logic [31:0]   rd2,
    input  logic [4:0]    rd,
    input  logic [5:0]    op,
    input  logic          memr,
    input  logic          memw,
    input  logic          regw,
    input  logic          mem2r,
    input  logic          flush,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          mem_stall,
    output logic [31:0]   wb_data,
    output logic [4:0]    wb_rd,
    output logic          wb_regw,
    output logic          wb_misalign
);

    mem_state_e  state;
    logic [3:0]  be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        misalign;
    logic        is_mem;
    logic        issue;
    logic        tmo_hit;

    mem_lane_align u_align (
        .op         (op),
        .addr_lo    (aluout[1:0]),
        .store_data (rd2),
        .load_word  (dmem_rdata),
        .be         (be),
        .wdata      (st_wdata),
        .load_data  (ld_data),
        .misalign   (misalign)
    );

    assign is_mem = memr | memw;
    assign issue  = (state == MS_IDLE) && is_mem && !flush && !misalign;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;

    // Counts request cycles; the last one is the abort cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (issue)
            tmo_cnt <= '0;
        else if (state == MS_ACCESS && !dmem_ack)
            tmo_cnt <= tmo_cnt + CW'(1);
    end

    assign tmo_hit = (state == MS_ACCESS) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC == 0);
    assign tmo_hit    = 1'b0;
`endif

    // Gated by rst_n so the stall drops immediately when reset hits mid-access.
    assign mem_stall = rst_n & (issue | ((state == MS_ACCESS) & ~dmem_ack & ~tmo_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MS_IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= '0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regw     <= 1'b0;
            wb_misalign <= 1'b0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (issue) begin
                        state       <= MS_ACCESS;
                        dmem_req    <= 1'b1;
                        dmem_we     <= memw;
                        dmem_addr   <= {aluout[AW-1:2], 2'b00};
                        dmem_be     <= be;
                        dmem_wdata  <= st_wdata;
                        wb_regw     <= 1'b0;
                        wb_misalign <= 1'b0;
                    end else begin
                        // Pass-through; a misaligned access becomes a flagged bubble.
                        wb_data     <= aluout;
                        wb_rd       <= rd;
                        wb_regw     <= regw & ~flush & ~(is_mem & misalign);
                        wb_misalign <= is_mem & misalign & ~flush;
                    end
                end
                MS_ACCESS: begin
                    if (dmem_ack) begin
                        state       <= MS_IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        dmem_be     <= 4'b0000;
                        wb_data     <= (memr & mem2r) ? ld_data : aluout;
                        wb_rd       <= rd;
                        wb_regw     <= regw & ~memw;
                        wb_misalign <= 1'b0;
                    end else if (tmo_hit) begin
                        state       <= MS_IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        dmem_be     <= 4'b0000;
                        wb_data     <= aluout;
                        wb_rd       <= rd;
                        wb_regw     <= 1'b0;
                        wb_misalign <= 1'b1;
                    end else begin
                        // Bubble while waiting so nothing is written back twice.
                        wb_regw     <= 1'b0;
                        wb_misalign <= 1'b0;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mips_pkg::*;

    logic        clk, rst_n;
    logic [31:0] aluout, rd2;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic        memr, memw, regw, mem2r, flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regw, wb_misalign;

    int n_pass  = 0;
    int n_total = 0;

    mem_wb_stage #(.AW(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .aluout(aluout), .rd2(rd2), .rd(rd), .op(op),
        .memr(memr), .memw(memw), .regw(regw), .mem2r(mem2r), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regw(wb_regw),
        .wb_misalign(wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        op = 6'h00; memr = 0; memw = 0; regw = 0; mem2r = 0; flush = 0;
        aluout = 32'h0; rd2 = 32'h0; rd = 5'd0; dmem_ack = 0; dmem_rdata = 32'h0;
    endtask

    // Drives one memory instruction; memory acks on request cycle ack_at.
    task automatic run_mem(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                           input logic r, input logic w, input logic m2r, input logic rw,
                           input logic [4:0] dst, input int ack_at, input logic [31:0] rdat,
                           output int stalls, output int reqs, output int bubble_bad,
                           output logic [31:0] c_addr, output logic [31:0] c_wdata,
                           output logic [3:0] c_be, output logic c_we);
        op = o; aluout = a; rd2 = d; memr = r; memw = w; mem2r = m2r; regw = rw; rd = dst;
        #1;
        stalls = int'(mem_stall); reqs = 0; bubble_bad = 0;
        c_addr = 'x; c_wdata = 'x; c_be = 'x; c_we = 1'bx;
        for (int i = 1; i <= ack_at; i++) begin
            step();
            if (i == ack_at) begin dmem_ack = 1; dmem_rdata = rdat; end
            #1;
            if (dmem_req) reqs++;
            if (mem_stall) stalls++;
            if (wb_regw) bubble_bad++;
            if (i == 1) begin c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we; end
        end
        step();
        nop();
    endtask

    task automatic test_reset();
        n_total++; if (dmem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", dmem_req); else n_pass++;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", mem_stall); else n_pass++;
        n_total++; if (dmem_be !== 4'b0) $display("FAIL reset_be got %b exp 0000", dmem_be); else n_pass++;
        n_total++; if ({wb_regw, wb_misalign, dmem_we} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {wb_regw, wb_misalign, dmem_we}); else n_pass++;
        n_total++; if ({wb_data, dmem_addr, dmem_wdata} !== 96'h0) $display("FAIL reset_data got %h exp 0", {wb_data, dmem_addr, dmem_wdata}); else n_pass++;
        n_total++; if (wb_rd !== 5'd0) $display("FAIL reset_rd got %0d exp 0", wb_rd); else n_pass++;
    endtask

    task automatic test_alu();
        regw = 1; aluout = 32'h1234; rd = 5'd5;
        #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL alu_stall got %b exp 0", mem_stall); else n_pass++;
        step();
        n_total++; if (wb_data !== 32'h1234) $display("FAIL alu_wb_data got %h exp 00001234", wb_data); else n_pass++;
        n_total++; if (wb_rd !== 5'd5) $display("FAIL alu_wb_rd got %0d exp 5", wb_rd); else n_pass++;
        n_total++; if (wb_regw !== 1'b1) $display("FAIL alu_wb_regw got %b exp 1", wb_regw); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL alu_req got %b exp 0", dmem_req); else n_pass++;
        nop();
    endtask

    task automatic test_loads();
        int s, q, b; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        // lb @0x103 from 0x80FF_0000: byte 3 = 0x80 -> sign-extended 0xFFFF_FF80
        run_mem(OP_LB, 32'h103, 32'h0, 1, 0, 1, 1, 5'd7, 3, 32'h80FF_0000, s, q, b, ca, cw, cb, cwe);
        n_total++; if (s != 3) $display("FAIL lb_stall_cycles got %0d exp 3", s); else n_pass++;
        n_total++; if (q != 3) $display("FAIL lb_req_cycles got %0d exp 3", q); else n_pass++;
        n_total++; if (b != 0) $display("FAIL lb_bubble got %0d exp 0", b); else n_pass++;
        n_total++; if (ca !== 32'h100 || cb !== 4'b1000 || cwe !== 1'b0) $display("FAIL lb_req_fields got addr %h be %b we %b exp 00000100 1000 0", ca, cb, cwe); else n_pass++;
        n_total++; if (wb_data !== 32'hFFFF_FF80) $display("FAIL lb_wb_data got %h exp ffffff80", wb_data); else n_pass++;
        n_total++; if (wb_regw !== 1'b1 || wb_rd !== 5'd7) $display("FAIL lb_wb_ctl got regw %b rd %0d exp 1 7", wb_regw, wb_rd); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL lb_req_drop got %b exp 0", dmem_req); else n_pass++;
        // lbu @0x102: byte 2 = 0xFF
        run_mem(OP_LBU, 32'h102, 32'h0, 1, 0, 1, 1, 5'd8, 2, 32'h80FF_0000, s, q, b, ca, cw, cb, cwe);
        n_total++; if (wb_data !== 32'h0000_00FF) $display("FAIL lbu_wb_data got %h exp 000000ff", wb_data); else n_pass++;
        // lh @0x102: upper half 0x80FF sign-extended
        run_mem(OP_LH, 32'h102, 32'h0, 1, 0, 1, 1, 5'd9, 1, 32'h80FF_0000, s, q, b, ca, cw, cb, cwe);
        n_total++; if (wb_data !== 32'hFFFF_80FF) $display("FAIL lh_wb_data got %h exp ffff80ff", wb_data); else n_pass++;
        // lw @0x100, ack on first request cycle -> single stall cycle
        run_mem(OP_LW, 32'h100, 32'h0, 1, 0, 1, 1, 5'd10, 1, 32'hDEAD_BEEF, s, q, b, ca, cw, cb, cwe);
        n_total++; if (s != 1) $display("FAIL lw_stall_cycles got %0d exp 1", s); else n_pass++;
        n_total++; if (wb_data !== 32'hDEAD_BEEF) $display("FAIL lw_wb_data got %h exp deadbeef", wb_data); else n_pass++;
    endtask

    task automatic test_stores();
        int s, q, b; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
        run_mem(OP_SH, 32'h202, 32'hAAAA_BEEF, 0, 1, 0, 1, 5'd3, 2, 32'h0, s, q, b, ca, cw, cb, cwe);
        n_total++; if (ca !== 32'h200) $display("FAIL sh_addr got %h exp 00000200", ca); else n_pass++;
        n_total++; if (cb !== 4'b1100) $display("FAIL sh_be got %b exp 1100", cb); else n_pass++;
        n_total++; if (cw !== 32'hBEEF_BEEF) $display("FAIL sh_wdata got %h exp beefbeef", cw); else n_pass++;
        n_total++; if (cwe !== 1'b1) $display("FAIL sh_we got %b exp 1", cwe); else n_pass++;
        n_total++; if (wb_regw !== 1'b0) $display("FAIL sh_wb_regw got %b exp 0", wb_regw); else n_pass++;
        run_mem(OP_SB, 32'h201, 32'h1234_5678, 0, 1, 0, 0, 5'd0, 1, 32'h0, s, q, b, ca, cw, cb, cwe);
        n_total++; if (cb !== 4'b0010 || cw !== 32'h7878_7878) $display("FAIL sb_lanes got be %b wdata %h exp 0010 78787878", cb, cw); else n_pass++;
        run_mem(OP_SW, 32'h204, 32'hCAFE_F00D, 0, 1, 0, 0, 5'd0, 1, 32'h0, s, q, b, ca, cw, cb, cwe);
        n_total++; if (cb !== 4'b1111 || cw !== 32'hCAFE_F00D) $display("FAIL sw_lanes got be %b wdata %h exp 1111 cafef00d", cb, cw); else n_pass++;
    endtask

    task automatic test_misalign_flush();
        op = OP_LW; memr = 1; mem2r = 1; regw = 1; aluout = 32'h101; rd = 5'd4;
        #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL mis_stall got %b exp 0", mem_stall); else n_pass++;
        step();
        n_total++; if (dmem_req !== 1'b0) $display("FAIL mis_req got %b exp 0", dmem_req); else n_pass++;
        n_total++; if (wb_misalign !== 1'b1 || wb_regw !== 1'b0) $display("FAIL mis_wb got misalign %b regw %b exp 1 0", wb_misalign, wb_regw); else n_pass++;
        // flushed aligned load: no request, no write-back
        aluout = 32'h100; flush = 1;
        #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", mem_stall); else n_pass++;
        step();
        n_total++; if (dmem_req !== 1'b0 || wb_regw !== 1'b0 || wb_misalign !== 1'b0) $display("FAIL flush_wb got req %b regw %b mis %b exp 0 0 0", dmem_req, wb_regw, wb_misalign); else n_pass++;
        // stray ack in IDLE ignored
        nop(); regw = 1; aluout = 32'h55; rd = 5'd3; dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF; mem2r = 1;
        step();
        n_total++; if (wb_data !== 32'h55 || dmem_req !== 1'b0) $display("FAIL idle_ack got wb %h req %b exp 00000055 0", wb_data, dmem_req); else n_pass++;
        nop();
    endtask

    task automatic test_reset_mid_access();
        op = OP_LW; memr = 1; mem2r = 1; regw = 1; aluout = 32'h100; rd = 5'd6;
        step();
        n_total++; if (dmem_req !== 1'b1) $display("FAIL rst_mid_req_up got %b exp 1", dmem_req); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL rst_mid_async got req %b stall %b exp 0 0", dmem_req, mem_stall); else n_pass++;
        nop();
        step();
        rst_n = 1;
        step();
        n_total++; if (wb_regw !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL rst_mid_after got regw %b req %b stall %b exp 0 0 0", wb_regw, dmem_req, mem_stall); else n_pass++;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        op = OP_LW; memr = 1; mem2r = 1; regw = 1; aluout = 32'h300; rd = 5'd2;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!dmem_req) break;
            n++;
            if (!mem_stall) nop();
        end
        n_total++; if (n != 4) $display("FAIL tmo_req_cycles got %0d exp 4", n); else n_pass++;
        n_total++; if (wb_misalign !== 1'b1 || wb_regw !== 1'b0) $display("FAIL tmo_wb got mis %b regw %b exp 1 0", wb_misalign, wb_regw); else n_pass++;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL tmo_stall got %b exp 0", mem_stall); else n_pass++;
        nop();
    endtask
`endif

    initial begin
        rst_n = 0;
        nop();
        #2;
        test_reset();
        step(); step();
        rst_n = 1;
        test_alu();
        test_loads();
        test_stores();
        test_misalign_flush();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
